pipeline_stall_flush_sequencer: RTL and testbench

Central pipeline-control sequencer for the five-stage MIPS pipeline with BTB redirection. It consumes the hazard requests from the data bypass controller (load-use `Stall`) and from the EX-stage branch resolver (`BranchCLR`). It turns them into per-stage register enable and clear strobes, and runs the halt/drain/resume state machine. It also keeps the cycle, stall and flush performance counters shown on the panel.

---
 rtl/pipeline_ctrl_pkg.sv | 18 +
 rtl/pipeline_stall_flush_sequencer_event_counter.sv | 18 +
 rtl/pipeline_stall_flush_sequencer.sv | 86 ++++++++
 tb/tb_pipeline_stall_flush_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding, default counter widths and strobe patterns for the pipeline sequencer
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} seq_state_t;
  localparam int CNT_W = 32;
  localparam int EVT_W = 16;
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_clr;
    logic idex_clr;
  } strobe_t;
  localparam strobe_t S_NORM  = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_clr: 1'b0, idex_clr: 1'b0};
  localparam strobe_t S_FLUSH = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_clr: 1'b1, idex_clr: 1'b1};
  localparam strobe_t S_STALL = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_clr: 1'b0, idex_clr: 1'b1};
  localparam strobe_t S_HALT  = '{pc_en: 1'b0, ifid_en: 1'b1, ifid_clr: 1'b1, idex_clr: 1'b0};
  localparam strobe_t S_DRAIN = '{pc_en: 1'b0, ifid_en: 1'b1, ifid_clr: 1'b1, idex_clr: 1'b1};
  localparam strobe_t S_IDLE  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_clr: 1'b0, idex_clr: 1'b0};
endpackage

// File: rtl/pipeline_stall_flush_sequencer_event_counter.sv
// event_counter: wrapping up-counter with async active-high reset
//   clk_i, rst_i : clock and async reset
//   inc_i        : count enable for this cycle
//   cnt_o        : current count
module event_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);
  logic [WIDTH-1:0] cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_q + 1'b1;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_stall_flush_sequencer.sv
// pipeline_stall_flush_sequencer: turns load-use/redirect/halt requests into stage strobes, runs halt/drain/resume, keeps perf counters
//   CLK, RST                  : clock, async active-high reset
//   Stall, BranchCLR, Halt, Go: hazard/redirect/halt requests and resume
//   PC_En, IF_ID_En           : register write enables (Mealy)
//   IF_ID_CLR, ID_EX_CLR      : bubble-insert clears (Mealy)
//   Halted                    : core halted
//   CycleCnt/StallCnt/FlushCnt: performance counters
module pipeline_stall_flush_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = pipeline_ctrl_pkg::CNT_W,
  parameter int EVT_W        = pipeline_ctrl_pkg::EVT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Stall,
  input  logic             BranchCLR,
  input  logic             Halt,
  input  logic             Go,
  output logic             PC_En,
  output logic             IF_ID_En,
  output logic             IF_ID_CLR,
  output logic             ID_EX_CLR,
  output logic             Halted,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [EVT_W-1:0] StallCnt,
  output logic [EVT_W-1:0] FlushCnt
);
  seq_state_t state_q, state_d;
  logic [2:0] dcnt_q, dcnt_d;
  strobe_t    st;
  logic       stall_inc, flush_inc;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= RUN;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  always_comb begin
    st        = S_NORM;
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state_q)
      RUN: begin
        // redirect wins: any Stall/Halt this cycle belongs to the wrong path
        if (BranchCLR) begin
          st        = S_FLUSH;
          flush_inc = 1'b1;
        end else if (Stall) begin
          st        = S_STALL;
          stall_inc = 1'b1;
        end else if (Halt) begin
          st      = S_HALT;
          state_d = DRAIN;
          dcnt_d  = '0;
        end
      end
      DRAIN: begin
        // an older branch redirecting cancels the halt
        if (BranchCLR) begin
          st        = S_FLUSH;
          flush_inc = 1'b1;
          state_d   = RUN;
        end else begin
          st      = S_DRAIN;
          dcnt_d  = dcnt_q + 3'd1;
          state_d = (dcnt_q == 3'(DRAIN_CYCLES - 1)) ? HALTED : DRAIN;
        end
      end
      default: begin
        st      = S_IDLE;
        state_d = Go ? RUN : HALTED;
      end
    endcase
  end
  assign {PC_En, IF_ID_En, IF_ID_CLR, ID_EX_CLR} = st;
  assign Halted = (state_q == HALTED);
  event_counter #(.WIDTH(CNT_W)) u_cycle (.clk_i(CLK), .rst_i(RST), .inc_i(!Halted), .cnt_o(CycleCnt));
  event_counter #(.WIDTH(EVT_W)) u_stall (.clk_i(CLK), .rst_i(RST), .inc_i(stall_inc), .cnt_o(StallCnt));
  event_counter #(.WIDTH(EVT_W)) u_flush (.clk_i(CLK), .rst_i(RST), .inc_i(flush_inc), .cnt_o(FlushCnt));
endmodule

// File: tb/tb_pipeline_stall_flush_sequencer.sv
// tb_pipeline_stall_flush_sequencer: directed checks of strobes, halt/drain/resume and counters
module tb_pipeline_stall_flush_sequencer;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Stall = 1'b0, BranchCLR = 1'b0, Halt = 1'b0, Go = 1'b0;
  logic        PC_En, IF_ID_En, IF_ID_CLR, ID_EX_CLR, Halted;
  logic [31:0] CycleCnt;
  logic [15:0] StallCnt, FlushCnt;
  int          checks = 0, passed = 0;

  pipeline_stall_flush_sequencer #(.DRAIN_CYCLES(3), .CNT_W(32), .EVT_W(16)) dut (
    .CLK(CLK), .RST(RST), .Stall(Stall), .BranchCLR(BranchCLR), .Halt(Halt), .Go(Go),
    .PC_En(PC_En), .IF_ID_En(IF_ID_En), .IF_ID_CLR(IF_ID_CLR), .ID_EX_CLR(ID_EX_CLR),
    .Halted(Halted), .CycleCnt(CycleCnt), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic strobes(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, PC_En, IF_ID_En, IF_ID_CLR, ID_EX_CLR}, {28'd0, exp});
  endtask

  task automatic counts(input string tag, input int c, input int s, input int f);
    chk({tag, "_cyc"}, CycleCnt, c);
    chk({tag, "_stall"}, {16'd0, StallCnt}, s);
    chk({tag, "_flush"}, {16'd0, FlushCnt}, f);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2;
    strobes("rst_strobes", 4'b1100);
    chk("rst_halted", Halted, 0);
    counts("rst", 0, 0, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      strobes("idle", 4'b1100);
      tick;
    end
    counts("idle", 5, 0, 0);
    Stall = 1'b1;
    #1;
    strobes("stall1", 4'b0001);
    tick;
    strobes("stall2", 4'b0001);
    tick;
    Stall = 1'b0;
    #1;
    strobes("stall_done", 4'b1100);
    counts("stall", 7, 2, 0);
    Stall = 1'b1;
    BranchCLR = 1'b1;
    #1;
    strobes("stall_br", 4'b1111);
    tick;
    Stall = 1'b0;
    BranchCLR = 1'b0;
    #1;
    counts("stall_br", 8, 2, 1);
    Halt = 1'b1;
    #1;
    strobes("halt_accept", 4'b0110);
    tick;
    Halt = 1'b0;
    #1;
    strobes("drain", 4'b0111);
    chk("drain_halted0", Halted, 0);
    tick;
    chk("drain_halted1", Halted, 0);
    tick;
    chk("drain_halted2", Halted, 0);
    tick;
    chk("halted_4th_edge", Halted, 1);
    strobes("halted_strobes", 4'b0000);
    Stall = 1'b1;
    BranchCLR = 1'b1;
    Halt = 1'b1;
    #1;
    strobes("halted_ignore", 4'b0000);
    repeat (3) tick;
    Stall = 1'b0;
    BranchCLR = 1'b0;
    Halt = 1'b0;
    #1;
    chk("halted_stay", Halted, 1);
    counts("halted_frozen", 12, 2, 1);
    Go = 1'b1;
    #1;
    strobes("go_same_cycle", 4'b0000);
    tick;
    Go = 1'b0;
    #1;
    chk("resume_halted", Halted, 0);
    strobes("resume", 4'b1100);
    chk("resume_cyc", CycleCnt, 12);
    tick;
    chk("resume_cyc_next", CycleCnt, 13);
    Halt = 1'b1;
    #1;
    tick;
    Halt = 1'b0;
    BranchCLR = 1'b1;
    #1;
    strobes("drain_abort", 4'b1111);
    chk("drain_abort_halted", Halted, 0);
    tick;
    BranchCLR = 1'b0;
    #1;
    strobes("after_abort", 4'b1100);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("abort_no_halt", Halted, 0);
    end
    counts("abort", 18, 2, 2);
    Stall = 1'b1;
    Halt = 1'b1;
    #1;
    strobes("stall_over_halt", 4'b0001);
    tick;
    Stall = 1'b0;
    #1;
    strobes("halt_retry", 4'b0110);
    tick;
    Halt = 1'b0;
    repeat (3) tick;
    chk("halted_again", Halted, 1);
    counts("halted_again", 23, 3, 2);
    #2;
    RST = 1'b1;
    #1;
    strobes("async_rst_strobes", 4'b1100);
    chk("async_rst_halted", Halted, 0);
    counts("async_rst", 0, 0, 0);
    @(negedge CLK);
    RST = 1'b0;
    tick;
    counts("post_rst", 1, 0, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
